// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetch_state_t;

  localparam int FETCH_AW_DEF = 16;
  localparam int FETCH_DW_DEF = 16;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus plus IR valid/ready handshake toward the control unit.
interface instr_fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output mem_addr, mem_rd, ir, ir_valid,
    input  mem_rdata, ir_ready
  );

  modport slave (
    input  mem_addr, mem_rd, ir, ir_valid,
    output mem_rdata, ir_ready
  );
endinterface

// File: rtl/fetch_latency_timer.sv
// Loadable down-counter timing the instruction memory read latency; done when the count is zero.
module fetch_latency_timer #(
  parameter int MEM_LATENCY = 1,
  parameter int CW          = $clog2(MEM_LATENCY + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (count_q != '0)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC -> memory read -> IR -> valid/ready. Optional perf counter under FETCH_PERF_CNT_EN.
//  state | meaning
//  IDLE  | no fetch in flight     ISSUE | mem_rd and pc_incr strobe
//  WAIT  | memory latency         HOLD  | IR valid, waiting for ir_ready
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW          = FETCH_AW_DEF,
  parameter int DW          = FETCH_DW_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [AW-1:0]       pc_in,
  output logic                pc_incr,
  input  logic                enable,
  input  logic                flush,
  instr_fetch_unit_if.master  bus,
  output logic                busy,
  output logic [15:0]         fetch_count
);

  localparam int LW = $clog2(MEM_LATENCY + 1);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          timer_load;
  logic          timer_done;
  logic [LW-1:0] timer_load_val;

  assign timer_load_val = LW'(MEM_LATENCY - 1);

  fetch_latency_timer #(.MEM_LATENCY(MEM_LATENCY), .CW(LW)) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !flush) begin
          addr_d  = pc_in;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (timer_done) begin
          ir_d       = bus.mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          if (enable) begin
            addr_d  = pc_in;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush drops any returning word and the held instruction; refetch begins from IDLE.
    if (flush) begin
      state_d    = IDLE;
      addr_d     = addr_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // An increment in the flush cycle would override the PC load that caused the flush.
  assign pc_incr      = (state_q == ISSUE) && !flush;
  assign bus.mem_rd   = (state_q == ISSUE);
  assign bus.mem_addr = addr_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign busy         = (state_q != IDLE);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (ir_valid_q && bus.ir_ready && !flush && (fetch_count_q != 16'hFFFF))
      fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) fetch_count_q <= '0;
    else         fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: latency-1 instance for handshake/flush cases, latency-3 instance for throughput and count.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [15:0] EXP_CNT4 = 16'd4;
`else
  localparam logic [15:0] EXP_CNT4 = 16'd0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] pc_a, pc_b;
  logic        pc_incr_a, pc_incr_b;
  logic        enable_a, enable_b;
  logic        flush_a, flush_b;
  logic        busy_a, busy_b;
  logic [15:0] fetch_count_a, fetch_count_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  instr_fetch_unit_if #(.AW(16), .DW(16)) bus_a ();
  instr_fetch_unit_if #(.AW(16), .DW(16)) bus_b ();

  instr_fetch_unit #(.AW(16), .DW(16), .MEM_LATENCY(1)) dut_a (
    .clock(clock), .resetn(resetn), .pc_in(pc_a), .pc_incr(pc_incr_a),
    .enable(enable_a), .flush(flush_a), .bus(bus_a.master),
    .busy(busy_a), .fetch_count(fetch_count_a)
  );

  instr_fetch_unit #(.AW(16), .DW(16), .MEM_LATENCY(3)) dut_b (
    .clock(clock), .resetn(resetn), .pc_in(pc_b), .pc_incr(pc_incr_b),
    .enable(enable_b), .flush(flush_b), .bus(bus_b.master),
    .busy(busy_b), .fetch_count(fetch_count_b)
  );

  // Latency-3 memory: word {A5, addr[7:0]} appears exactly 3 cycles after the read strobe.
  logic [2:0]  rd_pipe;
  logic [15:0] addr_pipe [3];
  always @(posedge clock) begin
    rd_pipe      <= {rd_pipe[1:0], bus_b.mem_rd};
    addr_pipe[0] <= bus_b.mem_addr;
    addr_pipe[1] <= addr_pipe[0];
    addr_pipe[2] <= addr_pipe[1];
  end
  assign bus_b.mem_rdata = rd_pipe[2] ? {8'hA5, addr_pipe[2][7:0]} : 16'hEEEE;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_acc, issue_n, last, seen;

  initial begin
    resetn = 1'b0; enable_a = 1'b1; pc_a = 16'h0004; flush_a = 1'b0;
    bus_a.ir_ready = 1'b0; bus_a.mem_rdata = 16'hBAD0;
    enable_b = 1'b0; pc_b = 16'h0100; flush_b = 1'b0; bus_b.ir_ready = 1'b0;
    tick(); tick();

    // reset state
    check("rst_ir_valid", bus_a.ir_valid, 0);
    check("rst_mem_rd", bus_a.mem_rd, 0);
    check("rst_pc_incr", pc_incr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fetch_count", fetch_count_a, 0);
    check("rst_ir", bus_a.ir, 0);
    check("rst_mem_addr", bus_a.mem_addr, 0);
    check("rst_b_fetch_count", fetch_count_b, 0);
    resetn = 1'b1;

    // first fetch, latency 1
    tick();
    check("iss_mem_addr", bus_a.mem_addr, 16'h0004);
    check("iss_mem_rd", bus_a.mem_rd, 1);
    check("iss_pc_incr", pc_incr_a, 1);
    check("iss_busy", busy_a, 1);
    tick();
    check("wait_pc_incr", pc_incr_a, 0);
    check("wait_mem_rd", bus_a.mem_rd, 0);
    check("wait_ir_valid", bus_a.ir_valid, 0);
    bus_a.mem_rdata = 16'h1234;
    tick();
    bus_a.mem_rdata = 16'hBAD0;
    check("hold_ir", bus_a.ir, 16'h1234);
    check("hold_ir_valid", bus_a.ir_valid, 1);

    // stall in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ir", bus_a.ir, 16'h1234);
      check("stall_ir_valid", bus_a.ir_valid, 1);
      check("stall_mem_rd", bus_a.mem_rd, 0);
      check("stall_pc_incr", pc_incr_a, 0);
    end
    bus_a.ir_ready = 1'b1; pc_a = 16'h0005;
    tick();
    bus_a.ir_ready = 1'b0;
    check("b2b_mem_addr", bus_a.mem_addr, 16'h0005);
    check("b2b_mem_rd", bus_a.mem_rd, 1);
    check("b2b_ir_valid", bus_a.ir_valid, 0);

    // flush during WAIT
    tick();
    flush_a = 1'b1; bus_a.mem_rdata = 16'hDEAD; pc_a = 16'h0020;
    tick();
    flush_a = 1'b0;
    check("flw_ir_valid", bus_a.ir_valid, 0);
    check("flw_ir", bus_a.ir, 16'h1234);
    check("flw_busy", busy_a, 0);
    tick();
    check("refetch_mem_addr", bus_a.mem_addr, 16'h0020);
    check("refetch_pc_incr", pc_incr_a, 1);
    tick();
    bus_a.mem_rdata = 16'h5678;
    tick();
    bus_a.mem_rdata = 16'hBAD0;
    check("refetch_ir", bus_a.ir, 16'h5678);
    check("refetch_ir_valid", bus_a.ir_valid, 1);

    // flush in the ISSUE cycle
    bus_a.ir_ready = 1'b1; pc_a = 16'h0030;
    tick();
    bus_a.ir_ready = 1'b0;
    check("fli_mem_addr", bus_a.mem_addr, 16'h0030);
    flush_a = 1'b1;
    #1;
    check("fli_pc_incr", pc_incr_a, 0);
    check("fli_mem_rd", bus_a.mem_rd, 1);
    tick();
    check("fli_busy_next", busy_a, 0);
    check("fli_mem_rd_next", bus_a.mem_rd, 0);
    flush_a = 1'b0; enable_a = 1'b0;
    tick();
    check("idle_no_enable", busy_a, 0);

    // latency 3, back-to-back, ir_ready tied high
    enable_b = 1'b1; bus_b.ir_ready = 1'b1;
    n_acc = 0; issue_n = 0; last = 0;
    for (int c = 1; c <= 60 && n_acc < 4; c++) begin
      tick();
      if (pc_incr_b) begin
        check("b_issue_addr", bus_b.mem_addr, 32'(16'h0100 + issue_n));
        issue_n++;
        pc_b = pc_b + 16'd1;
      end
      if (bus_b.ir_valid) begin
        check("b_ir", bus_b.ir, 32'(16'hA500 + n_acc));
        check("b_period", c - last, 5);
        last = c;
        n_acc++;
        if (n_acc == 4) enable_b = 1'b0;
      end
    end
    check("b_accepts", n_acc, 4);
    tick();
    check("b_fetch_count", fetch_count_b, EXP_CNT4);
    check("b_idle", busy_b, 0);

    // flush together with ir_ready in HOLD: not counted
    enable_b = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (pc_incr_b) pc_b = pc_b + 16'd1;
      if (bus_b.ir_valid) seen = 1;
    end
    check("b_second_valid", seen, 1);
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0; enable_b = 1'b0;
    check("b_flush_ir_valid", bus_b.ir_valid, 0);
    check("b_flush_busy", busy_b, 0);
    check("b_flush_count", fetch_count_b, EXP_CNT4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
